seq_divider: RTL and testbench

Sequential unsigned restoring divider. It is the inverse-direction companion to the datapath's shift-and-add multiplier: the multiplier builds a product from partial sums, and this block recovers quotient and remainder by shift-and-subtract, one bit per clock. It sits beside the multiplier in the arithmetic datapath. Operands are loaded with a start strobe, and results are reported with a one-cycle done pulse.

---
 rtl/seq_divider.sv | 113 +++++++++++
 tb/tb_seq_divider.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock by shift-and-subtract.
// A start strobe loads the operands; a one-cycle done pulse reports quotient and remainder.
module seq_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        ZERO = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH:0]   r_reg;
    logic [CNT_W-1:0] count;

    logic [WIDTH+1:0] step;
    logic [WIDTH:0]   r_next;
    logic [WIDTH-1:0] q_next;

    // One restoring step: returns {new partial remainder, new quotient bit}.
    // r stays below d, so its top bit is always zero and drops out of the shift.
    function automatic logic [WIDTH+1:0] div_step(input logic [WIDTH:0]   r,
                                                  input logic             msb,
                                                  input logic [WIDTH-1:0] d);
        logic [WIDTH:0] t;
        logic [WIDTH:0] d_ext;
        t     = (WIDTH+1)'({r, msb});
        d_ext = {1'b0, d};
        if (t >= d_ext)
            return {t - d_ext, 1'b1};
        else
            return {t, 1'b0};
    endfunction

    always_comb begin
        step   = div_step(r_reg, q_reg[WIDTH-1], d_reg);
        r_next = step[WIDTH+1:1];
        q_next = {q_reg[WIDTH-2:0], step[0]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            d_reg       <= '0;
            q_reg       <= '0;
            r_reg       <= '0;
            count       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        d_reg       <= divisor;
                        q_reg       <= dividend;
                        r_reg       <= '0;
                        count       <= '0;
                        div_by_zero <= 1'b0;
                        if (divisor == '0) begin
                            state <= ZERO;
                        end else begin
                            state <= CALC;
                            busy  <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    q_reg <= q_next;
                    r_reg <= r_next;
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        quotient  <= q_next;
                        remainder <= r_next[WIDTH-1:0];
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                ZERO: begin
                    // q_reg still holds the dividend as latched at start.
                    quotient    <= '1;
                    remainder   <= q_reg;
                    div_by_zero <= 1'b1;
                    done        <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: stimulus pushes expected results, a monitor pops on done.
module tb_seq_divider;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    seq_divider #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic             dbz;
        int               at;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, expv, expv, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: q=%0d r=%0d with no division outstanding",
                         quotient, remainder);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("quotient",    32'(quotient),    32'(e.q));
                chk("remainder",   32'(remainder),   32'(e.r));
                chk("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
                chk("done_cycle",  32'(cyc),         32'(e.at));
            end
        end
    end

    // Called at the negedge just after start was accepted.
    task automatic expect_result(input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] r,
                                 input logic dbz);
        exp_t e;
        e.q   = q;
        e.r   = r;
        e.dbz = dbz;
        e.at  = cyc + (dbz ? 1 : WIDTH);
        exp_q.push_back(e);
    endtask

    // Present operands at a negedge, leave the task at the negedge after acceptance.
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!done) chk({name, "_timeout"}, 32'(done), 32'd1);
    endtask

    task automatic div_run(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] r);
        issue(a, b);
        expect_result(q, r, 1'b0);
        wait_done("div");
        @(negedge clk);
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_busy",      32'(busy),        32'd0);
        chk("rst_done",      32'(done),        32'd0);
        chk("rst_quotient",  32'(quotient),    32'd0);
        chk("rst_remainder", 32'(remainder),   32'd0);
        chk("rst_dbz",       32'(div_by_zero), 32'd0);

        // 100/7 with busy profile E0..E16
        issue(16'd100, 16'd7);
        expect_result(16'd14, 16'd2, 1'b0);
        for (int i = 0; i < WIDTH; i++) begin
            chk("busy_calc", 32'(busy), 32'd1);
            @(negedge clk);
        end
        chk("busy_end", 32'(busy), 32'd0);
        chk("done_end", 32'(done), 32'd1);
        @(negedge clk);
        chk("done_clears", 32'(done), 32'd0);

        div_run(16'hFFFF, 16'h0001, 16'hFFFF, 16'd0);
        div_run(16'hFFFF, 16'hFFFF, 16'd1,    16'd0);
        div_run(16'd5,    16'd9,    16'd0,    16'd5);

        // Divide by zero
        issue(16'd1234, 16'd0);
        expect_result(16'hFFFF, 16'd1234, 1'b1);
        chk("dbz_busy0", 32'(busy), 32'd0);
        @(negedge clk);
        chk("dbz_busy1", 32'(busy), 32'd0);
        chk("dbz_done",  32'(done), 32'd1);
        @(negedge clk);

        // Start while busy is ignored
        issue(16'd50, 16'd3);
        expect_result(16'd16, 16'd2, 1'b0);
        repeat (4) @(negedge clk);
        issue(16'd9, 16'd2);
        wait_done("ignored_start");
        @(negedge clk);

        // Back-to-back with start held high
        start    = 1'b1;
        dividend = 16'd1000;
        divisor  = 16'd10;
        @(negedge clk);
        expect_result(16'd100, 16'd0, 1'b0);
        wait_done("b2b_first");
        dividend = 16'd77;
        divisor  = 16'd8;
        @(negedge clk);
        start = 1'b0;
        expect_result(16'd9, 16'd5, 1'b0);
        wait_done("b2b_second");
        @(negedge clk);

        // Reset in the middle of an iteration (sampled at E8)
        issue(16'd40000, 16'd123);
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_busy",      32'(busy),        32'd0);
        chk("midrst_done",      32'(done),        32'd0);
        chk("midrst_quotient",  32'(quotient),    32'd0);
        chk("midrst_remainder", 32'(remainder),   32'd0);
        chk("midrst_dbz",       32'(div_by_zero), 32'd0);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("midrst_idle_busy", 32'(busy), 32'd0);
        div_run(16'd40000, 16'd123, 16'd325, 16'd25);

        chk("outstanding", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
